vedic_16x16: RTL and testbench
==============================

# vedic_16x16

Unsigned 16x16-bit multiplier that produces a full 32-bit product using the Vedic Urdhva-Tiryagbhyam (vertical-and-crosswise) decomposition. The product is registered. The block is the arithmetic core used by the convolution datapath. Operands are presented with a valid strobe, and the product emerges a fixed number of cycles later with a matching strobe.

## Interface
Parameters: none. Widths are fixed and come from the shared package.

- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  a and b are valid this cycle
- a  input  16  unsigned multiplicand
- b  input  16  unsigned multiplier
- out_valid  output  1  result holds the product of a valid operand pair
- result  output  32  unsigned product a*b

## Operation
- result = a * b, unsigned, exact, no truncation. Maximum value is 0xFFFF*0xFFFF = 0xFFFE0001.
- Decomposition:
  - Split each operand into 8-bit halves: aH/aL and bH/bL.
  - Compute four 8x8 products: pLL, pHL, pLH, pHH.
  - Combine as result = pLL + ((pHL + pLH) << 8) + (pHH << 16).
  - Each 8x8 product is built the same way from 4x4 products, and each 4x4 from 2x2 products.
  - A 2x2 product is formed from AND gates plus half adders.
  - No signed handling and no saturation.
- The pipeline accepts a new operand pair every cycle; there are no stall or backpressure inputs.
- out_valid is in_valid delayed by the pipeline latency.
- result updates only when the corresponding in_valid was 1. Otherwise it holds its last value.

## Timing
- Reset (rst_n=0, asynchronous): result=32'h0 and out_valid=0 immediately, independent of clk. All internal pipeline registers also clear.
- Release of rst_n is synchronous to the next rising edge; the first capture happens on that edge.
- Latency without VEDIC16_PIPE_EN:
  - Operands with in_valid=1 at rising edge N.
  - result/out_valid are valid after edge N, readable in cycle N+1.
  - Latency is 1 cycle.
- Latency with VEDIC16_PIPE_EN: 2 cycles.
- Throughput is 1 product per cycle in both configurations.
- Back-to-back valid inputs produce back-to-back valid outputs, in order.
- Reset asserted mid-operation discards all in-flight products; out_valid stays 0 until new valid inputs arrive after release.

## Configuration
- VEDIC16_PIPE_EN defined:
  - Adds a register stage after the four 8x8 partial products (pLL, pHL, pLH, pHH and the valid bit).
  - The final 16x16 combine happens in the second stage.
  - Latency is 2 cycles.
- VEDIC16_PIPE_EN undefined:
  - The whole tree is combinational into the single output register.
  - Latency is 1 cycle.
- Function, reset values and throughput are identical in both configurations.

## Structure
- Shared package vedic_pkg holds:
  - VEDIC_OP_W = 16 and VEDIC_PROD_W = 32.
  - Half-operand width 8.
  - Latency constant VEDIC_LAT, which is 1, or 2 when VEDIC16_PIPE_EN is defined.
- Sub-module vedic_8x8 is combinational, 8x8 -> 16. It is built internally from 4x4 and 2x2 Vedic stages.
- The top instantiates it four times and holds only the registers and the final adder.

## Test plan
- Reset: hold rst_n=0 with random a/b and in_valid=1 -> result=0x00000000 and out_valid=0. Assert rst_n asynchronously mid-cycle -> outputs clear with no clock edge.
- Directed products, one per cycle with in_valid=1:
  - 0x0030*0x0A23 -> 0x0001E690
  - 0x02A0*0x0A25 -> 0x001AA120
  - 0x0A13*0x0A73 -> 0x00694489
  - 0x0240*0x0A30 -> 0x0016EC00
  - Each appears after exactly VEDIC_LAT cycles, in order, with out_valid=1.
- Corners:
  - 0x0000*0xFFFF -> 0x00000000
  - 0x0001*0xABCD -> 0x0000ABCD
  - 0xFFFF*0xFFFF -> 0xFFFE0001
  - 0x8000*0x8000 -> 0x40000000
  - 0x00FF*0xFF00 -> 0x00FE0100
- Valid gaps: alternate in_valid 1/0 with changing operands -> out_valid mirrors the pattern delayed by VEDIC_LAT, and result holds across the invalid cycles.
- Mid-stream reset: issue 3 valid pairs, then assert rst_n before the last emerges -> no stale product ever appears with out_valid=1 after release.
- Random: 10k random a/b pairs compared against a*b. Run in both VEDIC16_PIPE_EN configurations.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared widths, latency and combine helper for the Vedic 16x16 multiplier.
// Optional feature macro: VEDIC16_PIPE_EN (adds a register stage after the 8x8 products).
package vedic_pkg;

  localparam int VEDIC_OP_W   = 16;
  localparam int VEDIC_PROD_W = 32;
  localparam int VEDIC_HALF_W = 8;

`ifdef VEDIC16_PIPE_EN
  localparam int VEDIC_LAT = 2;
`else
  localparam int VEDIC_LAT = 1;
`endif

  typedef logic [2*VEDIC_HALF_W-1:0] partial_t;
  typedef logic [VEDIC_PROD_W-1:0]   product_t;

  // Vertical-and-crosswise combine of the four 8x8 partial products.
  // The cross sum is kept one bit wider so its carry is not lost.
  function automatic product_t vedic_combine(input partial_t pll,
                                             input partial_t phl,
                                             input partial_t plh,
                                             input partial_t phh);
    logic [16:0] mid;
    mid = {1'b0, phl} + {1'b0, plh};
    return {16'h0, pll} + ({15'h0, mid} << 8) + {phh, 16'h0};
  endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational Vedic 8x8 -> 16 multiplier, built from 4x4 stages,
// which are in turn built from 2x2 stages made of AND gates and half adders.

// 2x2 stage: partial products via AND gates, columns summed with half adders.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t1, t2, t3, c1;

  // Bit products and the two half adders that ripple the column carries.
  always_comb begin
    t1   = a[1] & b[0];
    t2   = a[0] & b[1];
    t3   = a[1] & b[1];
    c1   = t1 & t2;
    p[0] = a[0] & b[0];
    p[1] = t1 ^ t2;
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
  end
endmodule

// 4x4 stage: four 2x2 products joined vertically and crosswise.
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] ll, hl, lh, hh;
  logic [4:0] mid;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(ll));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(hl));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(lh));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(hh));

  // Cross terms summed with carry, then placed between the low and high products.
  always_comb begin
    mid = {1'b0, hl} + {1'b0, lh};
    p   = {4'h0, ll} + ({3'h0, mid} << 2) + {hh, 4'h0};
  end
endmodule

// 8x8 stage: four 4x4 products joined vertically and crosswise.
module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] ll, hl, lh, hh;
  logic [8:0] mid;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(ll));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(hl));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(lh));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(hh));

  // Cross terms summed with carry, then placed between the low and high products.
  always_comb begin
    mid = {1'b0, hl} + {1'b0, lh};
    p   = {8'h0, ll} + ({7'h0, mid} << 4) + {hh, 8'h0};
  end
endmodule

// File: rtl/vedic_16x16.sv
// Registered unsigned 16x16 -> 32 Vedic multiplier.
// Optional feature macro: VEDIC16_PIPE_EN registers the four 8x8 products,
// giving 2-cycle latency instead of 1; throughput stays one product per cycle.
module vedic_16x16
  import vedic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [VEDIC_OP_W-1:0]   a,
  input  logic [VEDIC_OP_W-1:0]   b,
  output logic                    out_valid,
  output logic [VEDIC_PROD_W-1:0] result
);
  partial_t pll, phl, plh, phh;

  vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(pll));
  vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .p(phl));
  vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .p(plh));
  vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .p(phh));

`ifdef VEDIC16_PIPE_EN
  partial_t pll_q, phl_q, plh_q, phh_q;
  logic     valid_q;

  // First stage: hold the 8x8 products of a valid pair plus its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pll_q   <= '0;
      phl_q   <= '0;
      plh_q   <= '0;
      phh_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        pll_q <= pll;
        phl_q <= phl;
        plh_q <= plh;
        phh_q <= phh;
      end
    end
  end

  // Second stage: final combine into the output register, held on invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= valid_q;
      if (valid_q) begin
        result <= vedic_combine(pll_q, phl_q, plh_q, phh_q);
      end
    end
  end
`else
  // Single stage: whole tree feeds the output register, held on invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= vedic_combine(pll, phl, plh, phh);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vedic_16x16.sv
// Directed and random checks of vedic_16x16 against hand-computed and a*b values.
module tb_vedic_16x16;
  import vedic_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [31:0] result;

  int errors;
  int checks;

  // Reference pipeline: valid bits and expected products of recent cycles.
  logic        hist_v [0:2];
  logic [31:0] hist_p [0:2];
  logic        model_valid;
  logic [31:0] model_result;

  vedic_16x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      hist_v[i] = 1'b0;
      hist_p[i] = '0;
    end
    model_valid  = 1'b0;
    model_result = '0;
  endtask

  // Drive one cycle at the falling edge, then check both outputs just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] va, input logic [15:0] vb,
                               input logic [31:0] exp, input string tag);
    @(negedge clk);
    in_valid = v;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
    hist_v[2] = hist_v[1]; hist_p[2] = hist_p[1];
    hist_v[1] = hist_v[0]; hist_p[1] = hist_p[0];
    hist_v[0] = v;         hist_p[0] = exp;
    model_valid = hist_v[VEDIC_LAT-1];
    if (model_valid) model_result = hist_p[VEDIC_LAT-1];
    checkOutput({tag, ".valid"}, {31'h0, out_valid}, {31'h0, model_valid});
    checkOutput({tag, ".result"}, result, model_result);
  endtask

  logic [15:0] dir_a [0:8];
  logic [15:0] dir_b [0:8];
  logic [31:0] dir_p [0:8];

  initial begin
    logic [15:0] ra, rb;
    logic        rv;
    errors = 0;
    checks = 0;
    clearModel();

    dir_a[0] = 16'h0030; dir_b[0] = 16'h0A23; dir_p[0] = 32'h0001E690;
    dir_a[1] = 16'h02A0; dir_b[1] = 16'h0A25; dir_p[1] = 32'h001AA120;
    dir_a[2] = 16'h0A13; dir_b[2] = 16'h0A73; dir_p[2] = 32'h00694489;
    dir_a[3] = 16'h0240; dir_b[3] = 16'h0A30; dir_p[3] = 32'h0016EC00;
    dir_a[4] = 16'h0000; dir_b[4] = 16'hFFFF; dir_p[4] = 32'h00000000;
    dir_a[5] = 16'h0001; dir_b[5] = 16'hABCD; dir_p[5] = 32'h0000ABCD;
    dir_a[6] = 16'hFFFF; dir_b[6] = 16'hFFFF; dir_p[6] = 32'hFFFE0001;
    dir_a[7] = 16'h8000; dir_b[7] = 16'h8000; dir_p[7] = 32'h40000000;
    dir_a[8] = 16'h00FF; dir_b[8] = 16'hFF00; dir_p[8] = 32'h00FE0100;

    // Reset held with live operands and in_valid=1: outputs must stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h5678;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset.valid", {31'h0, out_valid}, 32'h0);
      checkOutput("reset.result", result, 32'h0);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed products and corners, back to back.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, dir_a[i], dir_b[i], dir_p[i], $sformatf("dir%0d", i));
    for (int i = 0; i < VEDIC_LAT + 1; i++) applyStimulus(1'b0, 16'h0, 16'h0, 32'h0, "drain");

    // Alternating valid with changing operands: result must hold across gaps.
    applyStimulus(1'b1, 16'h0003, 16'h0005, 32'h0000000F, "gap0");
    applyStimulus(1'b0, 16'h1111, 16'h2222, 32'h02468642, "gap1");
    applyStimulus(1'b1, 16'h0100, 16'h0100, 32'h00010000, "gap2");
    applyStimulus(1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, "gap3");
    applyStimulus(1'b1, 16'h1234, 16'h0010, 32'h00012340, "gap4");
    applyStimulus(1'b0, 16'h0007, 16'h0007, 32'h00000031, "gap5");
    applyStimulus(1'b1, 16'h0FFF, 16'h1000, 32'h00FFF000, "gap6");
    for (int i = 0; i < VEDIC_LAT + 1; i++) applyStimulus(1'b0, 16'h0, 16'h0, 32'h0, "gapdrain");

    // Asynchronous reset between edges must clear outputs immediately.
    applyStimulus(1'b1, 16'h00FF, 16'hFF00, 32'h00FE0100, "pre_async");
    applyStimulus(1'b1, 16'h8000, 16'h8000, 32'h40000000, "pre_async2");
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async.valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async.result", result, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();

    // Mid-stream reset: third pair never captured, nothing stale after release.
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mid0");
    applyStimulus(1'b1, 16'h0A13, 16'h0A73, 32'h00694489, "mid1");
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h0240;
    b        = 16'h0A30;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midrst.result", result, 32'h0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0240, 16'h0A30, 32'h0016EC00, "postrst");
    applyStimulus(1'b1, 16'h0002, 16'h0003, 32'h00000006, "postrst_new");

    // Random operands with mostly-valid strobes against the bench's own product.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(3, 0) != 0);
      applyStimulus(rv, ra, rb, {16'h0, ra} * {16'h0, rb}, "rand");
    end
    for (int i = 0; i < VEDIC_LAT; i++) applyStimulus(1'b0, 16'h0, 16'h0, 32'h0, "randdrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
